// File: rtl/dm_access_ctrl_if.sv
// Bundle between the memory stage, the access controller and the word-wide data memory.
// The controller takes the slave side; the requester/memory model takes the master side.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_a, dm_wd, dm_we, dm_pc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_a, dm_wd, dm_we, dm_pc
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer for a word-only data memory: alignment/range checks,
// sub-word load extension and read-modify-write for sub-word stores.
module dm_access_ctrl #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk_i,
  input  logic        reset_i,
  dm_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e      state_q;
  op_e         op_q;
  logic [1:0]  off_q;
  logic [15:0] wd_q;
  logic [31:0] pc_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] dm_a_q;
  logic [31:0] dm_wd_q;
  logic        dm_we_q;

  op_e         req_op;
  logic        acc_err_d;
  logic [31:0] rdata_ext_d;
  logic [31:0] merge_d;

  assign req_op = op_e'(bus.req_op);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_err_d = 1'b0;
    if (bus.req_addr >= 32'(MEM_BYTES)) acc_err_d = 1'b1;
    case (req_op)
      OP_LW, OP_SW:         if (bus.req_addr[1:0] != 2'b00) acc_err_d = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (bus.req_addr[0])            acc_err_d = 1'b1;
      default: ;
    endcase
  end

  // Lane selection is little-endian: byte k at [8k+7:8k], halfword h at [16h+15:16h].
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b      = bus.dm_rd[{off_q, 3'b000} +: 8];
    lane_h      = bus.dm_rd[{off_q[1], 4'b0000} +: 16];
    rdata_ext_d = bus.dm_rd;
    case (op_q)
      OP_LB:   rdata_ext_d = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  rdata_ext_d = {24'h0, lane_b};
      OP_LH:   rdata_ext_d = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  rdata_ext_d = {16'h0, lane_h};
      default: rdata_ext_d = bus.dm_rd;
    endcase
  end

  always_comb begin
    merge_d = bus.dm_rd;
    if (op_q == OP_SB) merge_d[{off_q, 3'b000} +: 8]     = wd_q[7:0];
    else               merge_d[{off_q[1], 4'b0000} +: 16] = wd_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      off_q       <= 2'b00;
      wd_q        <= '0;
      pc_q        <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      dm_a_q      <= '0;
      dm_wd_q     <= '0;
      dm_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= req_op;
            off_q   <= bus.req_addr[1:0];
            wd_q    <= bus.req_wdata[15:0];
            pc_q    <= bus.req_pc;
            ready_q <= 1'b0;
            if (acc_err_d) begin
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              dm_a_q <= {bus.req_addr[31:2], 2'b00};
              case (req_op)
                OP_SW: begin
                  dm_wd_q <= bus.req_wdata;
                  dm_we_q <= 1'b1;
                  state_q <= S_WRITE;
                end
                OP_SH, OP_SB: state_q <= S_MERGE;
                default:      state_q <= S_LOAD;
              endcase
            end
          end
        end
        S_LOAD: begin
          rdata_q     <= rdata_ext_d;
          rsp_valid_q <= 1'b1;
          dm_a_q      <= '0;
          state_q     <= S_RESP;
        end
        S_MERGE: begin
          // Address stays on the bus; the merged word goes out next cycle with the write strobe.
          dm_wd_q <= merge_d;
          dm_we_q <= 1'b1;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          dm_we_q     <= 1'b0;
          dm_a_q      <= '0;
          dm_wd_q     <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          rdata_q     <= '0;
          err_q       <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ready_q resets high so it reads 1 right after release; the reset term masks it meanwhile.
  assign bus.req_ready = ready_q & ~reset_i;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.dm_a      = dm_a_q;
  assign bus.dm_wd     = dm_wd_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.dm_pc     = pc_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a word-wide memory model and hand-computed expectations.
module tb_dm_access_ctrl;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                         SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic clk = 1'b0;
  logic reset;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(.MEM_BYTES(16384)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  int          we_cnt  = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  assign bus.dm_rd = mem[bus.dm_a[13:2]];

  always @(posedge clk) begin
    if (bus.dm_we) begin
      mem[bus.dm_a[13:2]] <= bus.dm_wd;
      we_cnt  = we_cnt + 1;
      last_wa = bus.dm_a;
      last_wd = bus.dm_wd;
    end
    if (bus.rsp_valid) rsp_cnt = rsp_cnt + 1;
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request from a negedge and returns just after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Latency counts negedges after the accepting edge until rsp_valid is seen.
  task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_we);
    int          we0;
    int          lat;
    logic [31:0] rd;
    logic        er;
    we0 = we_cnt;
    lat = 0;
    rd  = 32'hXXXX_XXXX;
    er  = 1'bx;
    pc_ctr = pc_ctr + 32'd4;
    issue(op, addr, wdata, pc_ctr);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
    check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ":rdata"}, rd, exp_rdata);
    check({tag, ":err"}, {31'd0, er}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ":pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, ":we"}, 32'(we_cnt - we0), 32'(exp_we));
    check({tag, ":pc"}, bus.dm_pc, pc_ctr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    int rsp0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_pc    = '0;
    repeat (3) @(negedge clk);
    check("rst:ready_low", {31'd0, bus.req_ready}, 32'd0);
    check("rst:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst:dm_we", {31'd0, bus.dm_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel:ready", {31'd0, bus.req_ready}, 32'd1);
    check("rel:rdata", bus.rsp_rdata, 32'd0);
    check("rel:err", {31'd0, bus.rsp_err}, 32'd0);
    check("rel:dm_a", bus.dm_a, 32'd0);
    check("rel:dm_wd", bus.dm_wd, 32'd0);
    check("rel:dm_pc", bus.dm_pc, 32'd0);

    // Word store then load.
    xact("sw10", SW, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1);
    check("sw10:wa", last_wa, 32'h10);
    check("sw10:wd", last_wd, 32'hDEAD_BEEF);
    xact("lw10", LW, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0);

    // Extension from word 0x80FF7F01.
    xact("sw20", SW, 32'h20, 32'h80FF_7F01, 2, 32'h0, 1'b0, 1);
    xact("lb23",  LB,  32'h23, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 0);
    xact("lbu23", LBU, 32'h23, 32'h0, 2, 32'h0000_0080, 1'b0, 0);
    xact("lb21",  LB,  32'h21, 32'h0, 2, 32'h0000_007F, 1'b0, 0);
    xact("lh22",  LH,  32'h22, 32'h0, 2, 32'hFFFF_80FF, 1'b0, 0);
    xact("lhu20", LHU, 32'h20, 32'h0, 2, 32'h0000_7F01, 1'b0, 0);

    // Read-modify-write; upper wdata bits are junk and must be ignored.
    xact("sw30", SW, 32'h30, 32'h1122_3344, 2, 32'h0, 1'b0, 1);
    xact("sb31", SB, 32'h31, 32'h1234_56AA, 3, 32'h0, 1'b0, 1);
    check("sb31:wa", last_wa, 32'h30);
    check("sb31:wd", last_wd, 32'h1122_AA44);
    xact("sh32", SH, 32'h32, 32'h9999_BEEF, 3, 32'h0, 1'b0, 1);
    check("sh32:wd", last_wd, 32'hBEEF_AA44);
    xact("lw30", LW, 32'h30, 32'h0, 2, 32'hBEEF_AA44, 1'b0, 0);

    // Errors and the range boundary.
    xact("err_lw12",   LW, 32'h12,   32'h0,         1, 32'h0, 1'b1, 0);
    xact("err_sh33",   SH, 32'h33,   32'h0000_FFFF, 1, 32'h0, 1'b1, 0);
    xact("err_sw4000", SW, 32'h4000, 32'h1234_5678, 1, 32'h0, 1'b1, 0);
    xact("err_lb4001", LB, 32'h4001, 32'h0,         1, 32'h0, 1'b1, 0);
    xact("sw3ffc", SW, 32'h3FFC, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1);
    xact("lw3ffc", LW, 32'h3FFC, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0);

    // Back-pressure: two SWs queued with req_valid held high throughout.
    @(negedge clk);
    bus.req_op    = SW;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h0000_0001;
    bus.req_valid = 1'b1;
    check("bp:ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h44;
    bus.req_wdata = 32'h0000_0002;
    @(negedge clk);
    check("bp:ready_write", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("bp:ready_resp", {31'd0, bus.req_ready}, 32'd0);
    check("bp:rsp1", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    check("bp:ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("bp:rsp1_gone", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp:ready_write2", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("bp:rsp2", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    check("bp:mem40", mem[16], 32'h0000_0001);
    check("bp:mem44", mem[17], 32'h0000_0002);

    // Reset asserted asynchronously while SB 0x30 sits in MERGE.
    we0  = we_cnt;
    rsp0 = rsp_cnt;
    issue(SB, 32'h30, 32'h0000_0055, 32'hABCD_0000);
    #2 reset = 1'b1;
    #1;
    check("rmo:dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("rmo:ready", {31'd0, bus.req_ready}, 32'd0);
    check("rmo:rsp", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rmo:ready_rel", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rmo:no_write", 32'(we_cnt - we0), 32'd0);
    check("rmo:no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    check("rmo:mem30", mem[12], 32'hBEEF_AA44);
    xact("rmo:lw30", LW, 32'h30, 32'h0, 2, 32'hBEEF_AA44, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencing controller between the pipeline's memory stage and the word-wide data memory. Accepts one load/store request at a time over a valid/ready handshake and checks alignment and range. Sub-word loads are sign- or zero-extended. Sub-word stores become a read-modify-write on the word-only memory port. Each completed request gets a single-cycle response pulse, so the memory stage stalls on `req_ready` low.

## Interface

- MEM_BYTES, 16384: size of the data memory in bytes (4096 words). Any address >= MEM_BYTES is out of range.
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; returns the block to IDLE immediately
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the sub-word value sits in the low bits
- req_pc  input  32  PC of the issuing instruction, forwarded for the write log
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load result; 0 for stores and errors
- rsp_err  output  1  request rejected for misalignment or out-of-range address; valid with rsp_valid
- dm_a  output  32  word-aligned address to the data memory
- dm_wd  output  32  write data to the data memory
- dm_we  output  1  data memory write enable
- dm_pc  output  32  latched req_pc, driven to the memory's pc input
- dm_rd  input  32  combinational read data from the data memory

## Operation

- **Handshake:** a request is accepted on a posedge where req_valid && req_ready. On accept, op, addr, wdata and pc are latched. req_ready is 1 only in IDLE and is forced to 0 while reset is high.
- **Checks at accept:**
  - LW/SW require addr[1:0]==0.
  - LH/LHU/SH require addr[0]==0.
  - All ops require addr < MEM_BYTES.
  - A failed check goes to RESP with rsp_err=1. dm_we is never asserted for a failed request.
- **States:** IDLE, LOAD, MERGE, WRITE, RESP.
  - IDLE, on accept: error → RESP; LW/LH/LHU/LB/LBU → LOAD; SW → WRITE; SH/SB → MERGE.
  - LOAD: dm_a = {addr[31:2],2'b00}. Extract the lane from dm_rd, extend it, register it into rsp_rdata, then → RESP.
  - MERGE: dm_a as in LOAD. Register dm_rd with the target lane replaced by wdata's low byte or halfword, then → WRITE.
  - WRITE: dm_a = aligned address, dm_wd = wdata (SW) or the merged word, dm_we = 1. Then → RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then → IDLE. There is no back-pressure on the response.
- **Lanes (little-endian):**
  - Byte k (addr[1:0]=k) occupies bits [8k+7:8k].
  - Halfword h (addr[1]=h) occupies bits [16h+15:16h].
  - LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend.
- **Idle outputs:** dm_a and dm_wd are 0 outside LOAD/MERGE/WRITE. dm_we is 1 only in WRITE. dm_pc holds the latched pc.
- All outputs are registered or decoded from state only; none has a combinational path from req_* inputs.

## Timing

- **Reset values:** state IDLE, req_ready 0 while reset is high and 1 after release, rsp_valid 0, rsp_rdata 0, rsp_err 0, dm_we 0, dm_a 0, dm_wd 0, dm_pc 0.
- **Latency,** with accept on edge t:
  - SW: write occurs at edge t+1 (WRITE), rsp_valid high in cycle t+1..t+2.
  - Loads: rsp_valid with data in the cycle after LOAD, i.e. 2 cycles after accept.
  - SH/SB: MERGE, WRITE, RESP; the response arrives 3 cycles after accept.
  - Error: rsp_valid the cycle after accept.
- **Throughput:** the next request can be accepted in the cycle following RESP, so a back-to-back SW sequence takes 3 cycles per request.
- **Reset mid-operation:** an asserted reset drops dm_we at once, discards the latched request and produces no response. A MERGE interrupted by reset leaves memory unmodified.
- req_valid while not ready is ignored. The requester holds the request until accepted.

## Test plan

- **Reset and word store/load:** reset, then SW addr 0x10 data 0xDEADBEEF → dm_we pulses once with dm_a=0x10 and dm_wd=0xDEADBEEF; response at accept+2. Then LW 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0.
- **Sign/zero extension:** memory word at 0x20 = 0x80FF7F01.
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- **Read-modify-write:** word at 0x30 = 0x11223344.
  - SB 0x31 data 0xAA → written word 0x1122AA44, response 3 cycles after accept.
  - Then SH 0x32 data 0xBEEF → 0xBEEFAA44.
- **Errors:** LW 0x12, SH 0x33 and SW 0x4000 (MEM_BYTES) → rsp_valid and rsp_err 1 the cycle after accept, dm_we never high, rsp_rdata 0.
- **Back-pressure:** hold req_valid with two queued requests → req_ready low from accept until after RESP, and the second request is accepted exactly one cycle after the first response.
- **Reset mid-op:** assert reset asynchronously during the MERGE of SB 0x30 → dm_we stays 0, no rsp_valid, word 0x30 unchanged, req_ready returns to 1 after release.
